nn_sequencer: RTL and testbench
===============================

# nn_sequencer

Central controller for the 4-neuron perceptron network. Accepts a byte stream on a valid/ready handshake, steers each byte into the parameter register file (24 bytes) or the neuron input registers (4 bytes), and runs 1–4 inference passes, feeding outputs back as inputs between passes. Replaces the free-running state counter in the top level. Drives write strobes, capture strobes and status flags for the existing datapath.

## Interface
Parameters:
- N_NEURONS, 4, neuron count and inputs per neuron
- PARAMS_PER_NEURON, 6, bytes per neuron in order w0,w1,w2,w3,bias,threshold
- DATA_W, 8, byte width
- SETTLE_CYCLES, 1, cycles between the last input write and capture (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  DATA_W  streamed byte
- in_valid  in  1  in_data valid
- in_ready  out  1  sequencer accepts a byte this cycle
- load_params  in  1  pulse: full load (24 params + 4 inputs), then run
- start  in  1  pulse: input-only load (4 bytes), then run
- cfg_passes  in  2  number of passes minus 1; sampled when leaving IDLE
- p_we  out  1  parameter write strobe
- p_addr  out  5  parameter index = neuron*6 + k
- p_wdata  out  DATA_W  parameter byte
- x_we  out  1  input register write strobe
- x_idx  out  2  input register index
- x_wdata  out  DATA_W  input byte
- fb_we  out  1  load all input registers from neuron outputs
- cap_en  out  1  capture neuron outputs into output register
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse when the final capture completes
- params_valid  out  1  a complete parameter set is loaded
- pass_cnt  out  2  index of the current pass

## Operation
- States: IDLE, LOAD_PARAM, LOAD_INPUT, SETTLE, CAPTURE, DONE.
- A byte is accepted when in_valid && in_ready. in_ready is decoded from state and is 1 only in LOAD_PARAM and LOAD_INPUT.
- IDLE: load_params → LOAD_PARAM with byte counter 0. Otherwise start with params_valid=1 → LOAD_INPUT. start with params_valid=0 is ignored. If both are asserted, load_params wins. Both are ignored while busy.
- LOAD_PARAM: byte n goes to p_addr=n. After byte 23 is accepted, params_valid←1 and the state moves to LOAD_INPUT.
- LOAD_INPUT: byte n goes to x_idx=n. After byte 3 is accepted, the state moves to SETTLE.
- SETTLE: stays for SETTLE_CYCLES cycles, then goes to CAPTURE.
- CAPTURE: one cycle. cap_en=1.
  - If pass_cnt == latched cfg_passes, go to DONE.
  - Otherwise fb_we=1 in the same cycle, pass_cnt++, and return to SETTLE.
- DONE: done=1 for one cycle, then IDLE.
- p_we/p_addr/p_wdata and x_we/x_idx/x_wdata are registered and appear one cycle after the accepting cycle. p_addr, x_idx and the wdata outputs hold their last value when not strobed.
- pass_cnt clears to 0 on leaving IDLE.
- in_valid low during a load stalls the sequencer indefinitely. There is no timeout.
- Starting a new load_params clears params_valid to 0 at entry to LOAD_PARAM.

## Timing
- Reset (async assert, sync release): state IDLE, counters 0, params_valid=0.
  - All strobes, busy, done and in_ready are 0.
  - p_addr, x_idx, pass_cnt and both wdata outputs are 0.
- Reset asserted mid-load or mid-run aborts immediately. Partially written parameters are not marked valid.
- Full load with in_valid held high, load_params seen in cycle 0:
  - in_ready is high in cycles 1–28.
  - The last x_we is in cycle 29.
  - SETTLE is cycle 29, CAPTURE is cycle 30, done is cycle 31, IDLE is cycle 32 (1 pass, SETTLE_CYCLES=1).
- Each additional pass adds SETTLE_CYCLES+1 cycles.
- The datapath inputs are stable from the cycle after x_we or fb_we. The perceptron is combinational, so cap_en captures after at least one full settled cycle.

## Structure
- Package nn_ctrl_pkg holds:
  - the state enum;
  - N_NEURONS, PARAMS_PER_NEURON, N_PARAM_BYTES=24, N_INPUT_BYTES=4.
- Sub-module nn_byte_loader holds the handshake, byte counter and registered write-strobe/address/data generation, parameterised by byte count. The FSM and pass counter stay in nn_sequencer.

## Test plan
- Reset, then load_params with bytes 0x01..0x1C streamed back-to-back:
  - p_we pulses 24× with p_addr 0..23 and data 0x01..0x18;
  - x_we pulses 4× with x_idx 0..3 and data 0x19..0x1C;
  - params_valid=1, done in cycle 31.
- start with params_valid=0 → no state change, in_ready stays 0. After a full load, start + 4 bytes → done 4+SETTLE+2 cycles after start; no p_we.
- cfg_passes=3 → 4 cap_en pulses, 3 fb_we pulses, pass_cnt sequence 0,1,2,3, single done.
- in_valid toggled 1/0 every cycle during load → 28 accepts over ≈56 cycles, strobe order and addresses unchanged.
- rst_n dropped after byte 10 of load_params → all outputs at reset values immediately, params_valid=0; a following start is ignored.
- load_params and start asserted together in IDLE → full 28-byte load. load_params asserted during SETTLE → ignored, run completes normally.

Source files
------------

// File: rtl/nn_ctrl_pkg.sv
// Shared constants and FSM state type for the perceptron network sequencer.
package nn_ctrl_pkg;

  localparam int unsigned N_NEURONS         = 4;
  localparam int unsigned PARAMS_PER_NEURON = 6;
  localparam int unsigned N_PARAM_BYTES     = N_NEURONS * PARAMS_PER_NEURON;
  localparam int unsigned N_INPUT_BYTES     = N_NEURONS;

  typedef enum logic [2:0] {
    StIdle,
    StLoadParam,
    StLoadInput,
    StSettle,
    StCapture,
    StDone
  } state_e;

endpackage

// File: rtl/nn_byte_loader.sv
// Byte-stream loader: accepts NumBytes bytes while enabled and emits registered
// write strobe, address and data one cycle after each accepting cycle.
module nn_byte_loader #(
  parameter int unsigned NumBytes = 24,
  parameter int unsigned AddrW    = 5,
  parameter int unsigned DataW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [DataW-1:0] in_data,
  output logic             ready,
  output logic             last,
  output logic             we,
  output logic [AddrW-1:0] addr,
  output logic [DataW-1:0] wdata
);

  logic [AddrW-1:0] cnt_q;
  logic             accept;

  assign ready  = en;
  assign accept = en && in_valid;
  assign last   = accept && (cnt_q == AddrW'(NumBytes - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      we    <= 1'b0;
      addr  <= '0;
      wdata <= '0;
    end else begin
      we <= accept;
      if (accept) begin
        addr  <= cnt_q;
        wdata <= in_data;
        // Wrap on the final byte so the next load starts from index 0.
        cnt_q <= last ? '0 : cnt_q + AddrW'(1);
      end
    end
  end

endmodule

// File: rtl/nn_sequencer.sv
// Central controller for the 4-neuron perceptron: steers streamed bytes into
// the parameter/input registers and sequences 1-4 settle/capture passes.
module nn_sequencer #(
  parameter int unsigned N_NEURONS         = 4,
  parameter int unsigned PARAMS_PER_NEURON = 6,
  parameter int unsigned DATA_W            = 8,
  parameter int unsigned SETTLE_CYCLES     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              load_params,
  input  logic              start,
  input  logic [1:0]        cfg_passes,
  output logic              p_we,
  output logic [4:0]        p_addr,
  output logic [DATA_W-1:0] p_wdata,
  output logic              x_we,
  output logic [1:0]        x_idx,
  output logic [DATA_W-1:0] x_wdata,
  output logic              fb_we,
  output logic              cap_en,
  output logic              busy,
  output logic              done,
  output logic              params_valid,
  output logic [1:0]        pass_cnt
);
  import nn_ctrl_pkg::*;

  localparam int unsigned SettleW = $clog2(SETTLE_CYCLES + 1);

  state_e             state_q;
  logic [1:0]         passes_q;
  logic [SettleW-1:0] settle_q;
  logic               p_ready, x_ready, p_last, x_last;

  assign in_ready = p_ready | x_ready;
  assign busy     = (state_q != StIdle);

  nn_byte_loader #(
    .NumBytes(N_NEURONS * PARAMS_PER_NEURON),
    .AddrW   (5),
    .DataW   (DATA_W)
  ) u_param_loader (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state_q == StLoadParam),
    .in_valid(in_valid),
    .in_data (in_data),
    .ready   (p_ready),
    .last    (p_last),
    .we      (p_we),
    .addr    (p_addr),
    .wdata   (p_wdata)
  );

  nn_byte_loader #(
    .NumBytes(N_NEURONS),
    .AddrW   (2),
    .DataW   (DATA_W)
  ) u_input_loader (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state_q == StLoadInput),
    .in_valid(in_valid),
    .in_data (in_data),
    .ready   (x_ready),
    .last    (x_last),
    .we      (x_we),
    .addr    (x_idx),
    .wdata   (x_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      passes_q     <= 2'd0;
      pass_cnt     <= 2'd0;
      settle_q     <= '0;
      params_valid <= 1'b0;
      cap_en       <= 1'b0;
      fb_we        <= 1'b0;
      done         <= 1'b0;
    end else begin
      cap_en <= 1'b0;
      fb_we  <= 1'b0;
      done   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (load_params) begin
            state_q      <= StLoadParam;
            params_valid <= 1'b0;
            pass_cnt     <= 2'd0;
            passes_q     <= cfg_passes;
          end else if (start && params_valid) begin
            state_q  <= StLoadInput;
            pass_cnt <= 2'd0;
            passes_q <= cfg_passes;
          end
        end
        StLoadParam: begin
          if (p_last) begin
            params_valid <= 1'b1;
            state_q      <= StLoadInput;
          end
        end
        StLoadInput: begin
          if (x_last) begin
            state_q  <= StSettle;
            settle_q <= '0;
          end
        end
        StSettle: begin
          if (settle_q == SettleW'(SETTLE_CYCLES - 1)) begin
            state_q <= StCapture;
            cap_en  <= 1'b1;
            // Feedback is issued alongside every capture except the last.
            fb_we   <= (pass_cnt != passes_q);
          end else begin
            settle_q <= settle_q + SettleW'(1);
          end
        end
        StCapture: begin
          if (pass_cnt == passes_q) begin
            state_q <= StDone;
            done    <= 1'b1;
          end else begin
            pass_cnt <= pass_cnt + 2'd1;
            settle_q <= '0;
            state_q  <= StSettle;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_sequencer.sv
// Directed scoreboard bench for nn_sequencer: expected write strobes are queued
// as bytes are streamed and popped when the DUT emits them.
module tb_nn_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       load_params = 1'b0;
  logic       start = 1'b0;
  logic [1:0] cfg_passes = '0;
  logic       p_we, x_we, fb_we, cap_en, busy, done, params_valid;
  logic [4:0] p_addr;
  logic [1:0] x_idx, pass_cnt;
  logic [7:0] p_wdata, x_wdata;

  nn_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .load_params (load_params),
    .start       (start),
    .cfg_passes  (cfg_passes),
    .p_we        (p_we),
    .p_addr      (p_addr),
    .p_wdata     (p_wdata),
    .x_we        (x_we),
    .x_idx       (x_idx),
    .x_wdata     (x_wdata),
    .fb_we       (fb_we),
    .cap_en      (cap_en),
    .busy        (busy),
    .done        (done),
    .params_valid(params_valid),
    .pass_cnt    (pass_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] a;
    logic [7:0] d;
  } ent_t;

  ent_t       p_exp[$];
  ent_t       x_exp[$];
  logic [1:0] pc_q[$];
  int total = 0, bad = 0;
  int cyc = 0, c0 = 0;
  int p_cnt, x_cnt, cap_cnt, fb_cnt, done_cnt, done_off, rdy_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboards strobes and tallies control pulses.
  always @(negedge clk) begin
    ent_t e;
    if (rst_n) begin
      if (in_ready) rdy_cnt++;
      if (p_we) begin
        p_cnt++;
        if (p_exp.size() == 0) check("p_we_unexpected", p_we, 0);
        else begin
          e = p_exp.pop_front();
          check("p_addr", p_addr, e.a);
          check("p_wdata", p_wdata, e.d);
        end
      end
      if (x_we) begin
        x_cnt++;
        if (x_exp.size() == 0) check("x_we_unexpected", x_we, 0);
        else begin
          e = x_exp.pop_front();
          check("x_idx", x_idx, e.a);
          check("x_wdata", x_wdata, e.d);
        end
      end
      if (cap_en) begin
        cap_cnt++;
        pc_q.push_back(pass_cnt);
      end
      if (fb_we) fb_cnt++;
      if (done) begin
        done_cnt++;
        done_off = cyc - c0;
      end
    end
  end

  task automatic clear_counts();
    p_cnt = 0; x_cnt = 0; cap_cnt = 0; fb_cnt = 0;
    done_cnt = 0; done_off = -1; rdy_cnt = 0;
    pc_q.delete();
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_in_ready"}, in_ready, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_p_we"}, p_we, 0);
    check({pfx, "_x_we"}, x_we, 0);
    check({pfx, "_fb_we"}, fb_we, 0);
    check({pfx, "_cap_en"}, cap_en, 0);
    check({pfx, "_params_valid"}, params_valid, 0);
    check({pfx, "_p_addr"}, p_addr, 0);
    check({pfx, "_x_idx"}, x_idx, 0);
    check({pfx, "_p_wdata"}, p_wdata, 0);
    check({pfx, "_x_wdata"}, x_wdata, 0);
    check({pfx, "_pass_cnt"}, pass_cnt, 0);
  endtask

  task automatic run(input bit full, input bit both, input bit toggle, input logic [1:0] passes,
                     input logic [7:0] base, input int lp_at, input int exp_off, input bit chk_rdy);
    int n, idx, it, t;
    logic [7:0] b;
    bit acc;
    n = full ? 28 : 4;
    for (int i = 0; i < n; i++) begin
      b = base + 8'(i);
      if (full && i < 24) p_exp.push_back({5'(i), b});
      else x_exp.push_back({5'(full ? i - 24 : i), b});
    end
    clear_counts();
    @(posedge clk); #1;
    c0 = cyc;
    cfg_passes  = passes;
    load_params = full;
    start       = !full || both;
    @(posedge clk); #1;
    load_params = 1'b0;
    start       = 1'b0;
    idx = 0;
    it  = 0;
    while (idx < n && it < 200) begin
      in_valid = toggle ? (it % 2 == 0) : 1'b1;
      in_data  = base + 8'(idx);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      it++;
    end
    in_valid = 1'b0;
    check("bytes_accepted", idx, n);
    t = 0;
    while (done_cnt == 0 && t < 100) begin
      load_params = (cyc - c0 == lp_at);
      @(posedge clk); #1;
      t++;
    end
    load_params = 1'b0;
    check("idle_busy", busy, 0);
    check("idle_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    check("stay_idle", busy, 0);
    check("done_count", done_cnt, 1);
    check("done_cycle", done_off, exp_off);
    check("cap_count", cap_cnt, 32'(passes) + 1);
    check("fb_count", fb_cnt, 32'(passes));
    for (int i = 0; i < pc_q.size(); i++) check("pass_cnt_seq", pc_q[i], i);
    check("p_we_count", p_cnt, full ? 24 : 0);
    check("x_we_count", x_cnt, 4);
    check("p_exp_drained", p_exp.size(), 0);
    check("x_exp_drained", x_exp.size(), 0);
    check("params_valid", params_valid, 1);
    if (chk_rdy) check("ready_cycles", rdy_cnt, 28);
  endtask

  initial begin
    int idx;
    bit acc;
    clear_counts();
    #12;
    check_reset_vals("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // start without a parameter set must be ignored
    clear_counts();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("start_ignored_busy", busy, 0);
    check("start_ignored_ready", rdy_cnt, 0);

    run(1'b1, 1'b0, 1'b0, 2'd0, 8'h01, -1, 31, 1'b1);  // full load, back-to-back
    run(1'b0, 1'b0, 1'b0, 2'd0, 8'h40, -1, 7, 1'b0);   // input-only
    run(1'b0, 1'b0, 1'b0, 2'd3, 8'h50, -1, 13, 1'b0);  // four passes
    run(1'b1, 1'b0, 1'b1, 2'd0, 8'h60, -1, 58, 1'b0);  // in_valid toggling
    run(1'b1, 1'b1, 1'b0, 2'd0, 8'hA0, -1, 31, 1'b1);  // load_params + start together
    run(1'b0, 1'b0, 1'b0, 2'd1, 8'hC0, 5, 9, 1'b0);    // load_params during SETTLE

    // Reset after ten parameter bytes
    clear_counts();
    for (int i = 0; i < 10; i++) p_exp.push_back({5'(i), 8'h80 + 8'(i)});
    @(posedge clk); #1;
    c0 = cyc;
    load_params = 1'b1;
    @(posedge clk); #1;
    load_params = 1'b0;
    idx = 0;
    for (int it = 0; it < 40 && idx < 10; it++) begin
      in_valid = 1'b1;
      in_data  = 8'h80 + 8'(idx);
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("abort");
    check("abort_p_we_count", p_cnt, 10);
    check("abort_p_exp_drained", p_exp.size(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_counts();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_start_busy", busy, 0);
    check("abort_start_ready", rdy_cnt, 0);
    check("abort_params_valid", params_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
